// File: rtl/game_pkg.sv
// Shared types and default parameters for the game director and its lane controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        INTRO     = 3'd2,
        PLAY      = 3'd3,
        HIT       = 3'd4,
        OVER      = 3'd5
    } game_state_t;

    localparam int DEF_NUM_LANES        = 3;
    localparam int DEF_SCORE_WIDTH      = 16;
    localparam int DEF_LIVES            = 3;
    localparam int DEF_COUNTDOWN_FRAMES = 5;
    localparam int DEF_SPAWN_GAP        = 8;
    localparam int DEF_SPAWN_THRESH     = 26;
    localparam int DEF_INVULN_FRAMES    = 30;

    // Width of a down-counter that must hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lane_ctrl.sv
// Button rising-edge detection and saturating player-lane register.
module lane_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              init_i,
    input  logic              btn_left_i,
    input  logic              btn_right_i,
    output logic [LANE_W-1:0] lane_o
);

    localparam logic [LANE_W-1:0] LANE_MID = LANE_W'(NUM_LANES / 2);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);

    logic              left_q;
    logic              right_q;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;
    logic              rise_l;
    logic              rise_r;

    // Edge history tracks the buttons in every state so a button held across
    // the transition into PLAY does not count as a fresh press.
    assign rise_l = btn_left_i & ~left_q;
    assign rise_r = btn_right_i & ~right_q;

    always_comb begin
        lane_d = lane_q;
        if (init_i) begin
            lane_d = LANE_MID;
        end else if (en_i) begin
            if (rise_l && !rise_r && lane_q != '0) begin
                lane_d = lane_q - LANE_ONE;
            end else if (rise_r && !rise_l && lane_q != LANE_MAX) begin
                lane_d = lane_q + LANE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            lane_q  <= LANE_MID;
        end else begin
            left_q  <= btn_left_i;
            right_q <= btn_right_i;
            lane_q  <= lane_d;
        end
    end

    assign lane_o = lane_q;

endmodule

// File: rtl/game_director.sv
// Game sequencing FSM: countdown/intro, spawning, scoring, lives and hit recovery.
// Optional high-score register enabled by defining DIRECTOR_HISCORE_EN.
module game_director
    import game_pkg::*;
#(
    parameter int NUM_LANES        = DEF_NUM_LANES,
    parameter int SCORE_WIDTH      = DEF_SCORE_WIDTH,
    parameter int LIVES            = DEF_LIVES,
    parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int SPAWN_GAP        = DEF_SPAWN_GAP,
    parameter int SPAWN_THRESH     = DEF_SPAWN_THRESH,
    parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         start,
    input  logic [19:0]                  random,
    input  logic                         intro_done,
    input  logic [NUM_LANES-1:0]         coin_hit,
    input  logic                         obst_hit,
    output logic [2:0]                   state,
    output logic [$clog2(NUM_LANES)-1:0] player_lane,
    output logic [NUM_LANES-1:0]         coin_spawn,
    output logic [NUM_LANES-1:0]         obst_spawn,
    output logic [SCORE_WIDTH-1:0]       score,
    output logic [2:0]                   lives,
    output logic                         invuln,
    output logic                         game_over,
    output logic [SCORE_WIDTH-1:0]       hiscore
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int GAP_W  = cnt_width(SPAWN_GAP);
    localparam int INV_W  = cnt_width(INVULN_FRAMES);
    localparam int CD_W   = cnt_width(COUNTDOWN_FRAMES);
    localparam int CNT_W  = $clog2(NUM_LANES + 1);

    game_state_t            state_q, state_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [2:0]             lives_q, lives_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [INV_W-1:0]       inv_q, inv_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic [NUM_LANES-1:0]   obst_q, obst_d;
    logic [NUM_LANES-1:0]   coin_q, coin_d;
    logic                   invuln_q;
    logic                   game_over_q;
    logic                   lane_init;
    logic                   lane_en;
    logic [CNT_W-1:0]       coin_cnt;
    logic [SCORE_WIDTH:0]   score_sum;
    logic [7:0]             obst_lane;
    logic                   unused_random;

    assign obst_lane     = random[15:8] % 8'(NUM_LANES);
    assign unused_random = ^random[19:16];
    assign lane_en       = (state_q == PLAY) || (state_q == HIT);

    always_comb begin
        coin_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            coin_cnt = coin_cnt + CNT_W'(coin_hit[i]);
        end
        score_sum = {1'b0, score_q} + (SCORE_WIDTH + 1)'(coin_cnt);
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        gap_d     = gap_q;
        inv_d     = inv_q;
        cd_d      = cd_q;
        obst_d    = '0;
        coin_d    = '0;
        lane_init = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = COUNTDOWN;
            end
            COUNTDOWN: begin
                if (frame_tick) begin
                    if (cd_q <= CD_W'(1)) begin
                        cd_d    = '0;
                        state_d = INTRO;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end
            INTRO: begin
                if (intro_done) state_d = PLAY;
            end
            PLAY: begin
                if (frame_tick) begin
                    if (gap_q == '0 && random[7:0] < 8'(SPAWN_THRESH)) begin
                        obst_d = NUM_LANES'(1) << obst_lane;
                        gap_d  = GAP_W'(SPAWN_GAP);
                    end else if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                    // A lane getting an obstacle never also gets a coin on that tick.
                    for (int i = 0; i < NUM_LANES; i++) begin
                        coin_d[i] = (random[3*i +: 3] == 3'b111) && !obst_d[i];
                    end
                end
                if (obst_hit) begin
                    lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                    if (lives_q <= 3'd1) begin
                        state_d = OVER;
                    end else begin
                        state_d = HIT;
                        inv_d   = INV_W'(INVULN_FRAMES);
                    end
                end
            end
            HIT: begin
                if (frame_tick) begin
                    if (inv_q <= INV_W'(1)) begin
                        inv_d   = '0;
                        state_d = PLAY;
                    end else begin
                        inv_d = inv_q - INV_W'(1);
                    end
                end
            end
            OVER: begin
                if (start) state_d = COUNTDOWN;
            end
            default: state_d = IDLE;
        endcase

        // Coins collected on the fatal-hit cycle still count; OVER itself freezes score.
        if (lane_en) begin
            score_d = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];
        end

        if (state_d == COUNTDOWN && state_q != COUNTDOWN) begin
            score_d   = '0;
            lives_d   = 3'(LIVES);
            cd_d      = CD_W'(COUNTDOWN_FRAMES);
            lane_init = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            gap_q       <= '0;
            inv_q       <= '0;
            cd_q        <= '0;
            obst_q      <= '0;
            coin_q      <= '0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            gap_q       <= gap_d;
            inv_q       <= inv_d;
            cd_q        <= cd_d;
            obst_q      <= obst_d;
            coin_q      <= coin_d;
            invuln_q    <= (state_d == HIT);
            game_over_q <= (state_d == OVER);
        end
    end

    lane_ctrl #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_lane_ctrl (
        .clk         (clk),
        .rst         (rst),
        .en_i        (lane_en),
        .init_i      (lane_init),
        .btn_left_i  (btn_left),
        .btn_right_i (btn_right),
        .lane_o      (player_lane)
    );

`ifdef DIRECTOR_HISCORE_EN
    logic [SCORE_WIDTH-1:0] hiscore_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore_q <= '0;
        end else if (state_d == OVER && state_q != OVER && score_d > hiscore_q) begin
            hiscore_q <= score_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

    assign state      = state_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign obst_spawn = obst_q;
    assign coin_spawn = coin_q;
    assign invuln     = invuln_q;
    assign game_over  = game_over_q;

endmodule
